systolic_row: RTL and testbench

SYSTOLIC_ROW -- requirements
Module: systolic_row

---
 rtl/systolic_pkg.sv | 13 +
 rtl/mac_pe.sv | 131 +++++++++++++
 rtl/systolic_row.sv | 81 ++++++++
 tb/tb_systolic_row.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared PE state type and default widths for the systolic row.
package systolic_pkg;

    localparam int unsigned DefDataWidth = 32;
    localparam int unsigned DefAccWidth  = 2 * DefDataWidth + 4;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StAccum = 2'd1,
        StDone  = 2'd2
    } pe_state_e;

endpackage

// File: rtl/mac_pe.sv
// One multiply-accumulate PE: forwards A east and B south, emits C on the last term.
// Define SYSTOLIC_ROW_SAT_EN to saturate the accumulator instead of wrapping.
module mac_pe
    import systolic_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned ACC_WIDTH  = DefAccWidth
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic                  a_valid_i,
    input  logic                  a_last_i,
    output logic                  a_ready_o,
    output logic [DATA_WIDTH-1:0] a_o,
    output logic                  a_valid_o,
    output logic                  a_last_o,
    input  logic                  a_ready_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    input  logic                  b_valid_i,
    output logic                  b_ready_o,
    output logic [DATA_WIDTH-1:0] b_o,
    output logic                  b_valid_o,
    input  logic                  b_ready_i,
    output logic [ACC_WIDTH-1:0]  c_o,
    output logic                  c_valid_o,
    input  logic                  c_ready_i,
    output logic                  busy_o
);

    localparam int unsigned ProdWidth = 2 * DATA_WIDTH;

    pe_state_e                   state_q, state_d;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic signed [ACC_WIDTH-1:0] sum;
    logic [ACC_WIDTH-1:0]        c_q, c_d;
    logic                        c_valid_q, c_valid_d;
    logic [DATA_WIDTH-1:0]       a_q, b_q;
    logic                        a_valid_q, a_last_q, b_valid_q;
    logic                        fwd_free, c_free, can_fire, fire;
    logic signed [ProdWidth-1:0] prod;
    logic signed [ACC_WIDTH-1:0] prod_ext;

    // Readiness never looks at our own side's valid, only at the partner operand.
    assign fwd_free  = (!a_valid_q || a_ready_i) && (!b_valid_q || b_ready_i);
    assign c_free    = !a_last_i || !c_valid_q || c_ready_i;
    assign can_fire  = fwd_free && c_free;
    assign a_ready_o = can_fire && b_valid_i;
    assign b_ready_o = can_fire && a_valid_i;
    assign fire      = can_fire && a_valid_i && b_valid_i;

    assign prod     = $signed(a_i) * $signed(b_i);
    assign prod_ext = ACC_WIDTH'(prod);

`ifdef SYSTOLIC_ROW_SAT_EN
    logic signed [ACC_WIDTH:0] sum_wide;
    assign sum_wide = {acc_q[ACC_WIDTH-1], acc_q} + {prod_ext[ACC_WIDTH-1], prod_ext};

    always_comb begin
        sum = sum_wide[ACC_WIDTH-1:0];
        if (sum_wide[ACC_WIDTH] != sum_wide[ACC_WIDTH-1]) begin
            sum = sum_wide[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                      : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end
    end
`else
    assign sum = acc_q + prod_ext;
`endif

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        c_d       = c_q;
        c_valid_d = c_valid_q;
        if (c_valid_q && c_ready_i) begin
            c_valid_d = 1'b0;
        end
        if (fire) begin
            if (a_last_i) begin
                state_d   = StDone;
                acc_d     = '0;
                c_d       = sum;
                c_valid_d = 1'b1;
            end else begin
                state_d = StAccum;
                acc_d   = sum;
            end
        end else if (state_q == StDone && c_ready_i) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            acc_q     <= '0;
            c_q       <= '0;
            c_valid_q <= 1'b0;
            a_q       <= '0;
            a_valid_q <= 1'b0;
            a_last_q  <= 1'b0;
            b_q       <= '0;
            b_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            c_q       <= c_d;
            c_valid_q <= c_valid_d;
            if (fire) begin
                a_q       <= a_i;
                a_last_q  <= a_last_i;
                a_valid_q <= 1'b1;
                b_q       <= b_i;
                b_valid_q <= 1'b1;
            end else begin
                if (a_ready_i) a_valid_q <= 1'b0;
                if (b_ready_i) b_valid_q <= 1'b0;
            end
        end
    end

    assign a_o       = a_q;
    assign a_valid_o = a_valid_q;
    assign a_last_o  = a_last_q;
    assign b_o       = b_q;
    assign b_valid_o = b_valid_q;
    assign c_o       = c_q;
    assign c_valid_o = c_valid_q;
    assign busy_o    = (state_q != StIdle);

endmodule

// File: rtl/systolic_row.sv
// Row of COLS mac_pe cells: A flows east through every PE, each column has its own B and C.
// Define SYSTOLIC_ROW_SAT_EN to make every accumulator saturate instead of wrap.
module systolic_row
    import systolic_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned COLS       = 4,
    parameter int unsigned ACC_WIDTH  = 2 * DATA_WIDTH + 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_WIDTH-1:0]      a_in,
    input  logic                       a_in_valid,
    input  logic                       a_in_last,
    output logic                       a_in_ready,
    output logic [DATA_WIDTH-1:0]      a_out,
    output logic                       a_out_valid,
    output logic                       a_out_last,
    input  logic                       a_out_ready,
    input  logic [COLS*DATA_WIDTH-1:0] b_in,
    input  logic [COLS-1:0]            b_in_valid,
    output logic [COLS-1:0]            b_in_ready,
    output logic [COLS*DATA_WIDTH-1:0] b_out,
    output logic [COLS-1:0]            b_out_valid,
    input  logic [COLS-1:0]            b_out_ready,
    output logic [COLS*ACC_WIDTH-1:0]  c_out,
    output logic [COLS-1:0]            c_valid,
    input  logic [COLS-1:0]            c_ready,
    output logic                       busy
);

    // Hop c of the A chain feeds PE c; hop COLS is the east edge of the row.
    logic [(COLS+1)*DATA_WIDTH-1:0] a_data_chain;
    logic [COLS:0]                  a_valid_chain;
    logic [COLS:0]                  a_last_chain;
    logic [COLS:0]                  a_ready_chain;
    logic [COLS-1:0]                pe_busy;

    assign a_data_chain[DATA_WIDTH-1:0] = a_in;
    assign a_valid_chain[0]             = a_in_valid;
    assign a_last_chain[0]              = a_in_last;
    assign a_in_ready                   = a_ready_chain[0];

    assign a_out                = a_data_chain[COLS*DATA_WIDTH +: DATA_WIDTH];
    assign a_out_valid          = a_valid_chain[COLS];
    assign a_out_last           = a_last_chain[COLS];
    assign a_ready_chain[COLS]  = a_out_ready;

    generate
        for (genvar c = 0; c < COLS; c++) begin : g_pe
            mac_pe #(
                .DATA_WIDTH (DATA_WIDTH),
                .ACC_WIDTH  (ACC_WIDTH)
            ) u_pe (
                .clk_i      (clk),
                .rst_ni     (rst),
                .a_i        (a_data_chain[c*DATA_WIDTH +: DATA_WIDTH]),
                .a_valid_i  (a_valid_chain[c]),
                .a_last_i   (a_last_chain[c]),
                .a_ready_o  (a_ready_chain[c]),
                .a_o        (a_data_chain[(c+1)*DATA_WIDTH +: DATA_WIDTH]),
                .a_valid_o  (a_valid_chain[c+1]),
                .a_last_o   (a_last_chain[c+1]),
                .a_ready_i  (a_ready_chain[c+1]),
                .b_i        (b_in[c*DATA_WIDTH +: DATA_WIDTH]),
                .b_valid_i  (b_in_valid[c]),
                .b_ready_o  (b_in_ready[c]),
                .b_o        (b_out[c*DATA_WIDTH +: DATA_WIDTH]),
                .b_valid_o  (b_out_valid[c]),
                .b_ready_i  (b_out_ready[c]),
                .c_o        (c_out[c*ACC_WIDTH +: ACC_WIDTH]),
                .c_valid_o  (c_valid[c]),
                .c_ready_i  (c_ready[c]),
                .busy_o     (pe_busy[c])
            );
        end
    endgenerate

    assign busy = |pe_busy;

endmodule

// File: tb/tb_systolic_row.sv
// Scoreboard bench for systolic_row (DW=8, ACC=16, COLS=2); honours SYSTOLIC_ROW_SAT_EN.
module tb_systolic_row;

    localparam int DW  = 8;
    localparam int ACC = 16;
    localparam int NC  = 2;

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } tok_t;

    logic              clk;
    logic              rst;
    logic [DW-1:0]     a_in, a_out;
    logic              a_in_valid, a_in_last, a_in_ready;
    logic              a_out_valid, a_out_last, a_out_ready;
    logic [NC*DW-1:0]  b_in, b_out;
    logic [NC-1:0]     b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [NC*ACC-1:0] c_out;
    logic [NC-1:0]     c_valid, c_ready;
    logic              busy;

    int checks   = 0;
    int failures = 0;

    tok_t          drv_a[$], exp_a[$];
    logic [DW-1:0] drv_b[NC][$], exp_b[NC][$];
    longint        exp_c[NC][$];
    int            va[$];
    int            vb[NC][$];
    int            cvc[NC];
    bit            rand_ready = 1'b0;
    bit            gap_en     = 1'b0;
    logic [NC-1:0] c_ready_cfg = '1;

    systolic_row #(
        .DATA_WIDTH (DW),
        .COLS       (NC),
        .ACC_WIDTH  (ACC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .a_in        (a_in),
        .a_in_valid  (a_in_valid),
        .a_in_last   (a_in_last),
        .a_in_ready  (a_in_ready),
        .a_out       (a_out),
        .a_out_valid (a_out_valid),
        .a_out_last  (a_out_last),
        .a_out_ready (a_out_ready),
        .b_in        (b_in),
        .b_in_valid  (b_in_valid),
        .b_in_ready  (b_in_ready),
        .b_out       (b_out),
        .b_out_valid (b_out_valid),
        .b_out_ready (b_out_ready),
        .c_out       (c_out),
        .c_valid     (c_valid),
        .c_ready     (c_ready),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference accumulate: exact sum, then saturate or wrap to ACC signed bits.
    function automatic longint acc_step(input longint acc, input longint p);
        longint s, m;
        s = acc + p;
        m = longint'(1) << ACC;
`ifdef SYSTOLIC_ROW_SAT_EN
        if (s > m / 2 - 1) s = m / 2 - 1;
        else if (s < -(m / 2)) s = -(m / 2);
`else
        s = s % m;
        if (s >= m / 2) s -= m;
        else if (s < -(m / 2)) s += m;
`endif
        return s;
    endfunction

    function automatic int pending();
        int n;
        n = drv_a.size() + exp_a.size();
        for (int c = 0; c < NC; c++) n += drv_b[c].size() + exp_b[c].size() + exp_c[c].size();
        return n;
    endfunction

    task automatic term(input int a, input int b0, input int b1);
        va.push_back(a);
        vb[0].push_back(b0);
        vb[1].push_back(b1);
    endtask

    // Queue the staged terms for the drivers and push every expected output.
    task automatic issue(input bit has_last, input bit fixed, input longint f0, input longint f1);
        longint acc[NC];
        tok_t   t;
        logic [DW-1:0] bv;
        for (int c = 0; c < NC; c++) acc[c] = 0;
        for (int i = 0; i < va.size(); i++) begin
            t.d = DW'(va[i]);
            t.l = has_last && (i == va.size() - 1);
            drv_a.push_back(t);
            exp_a.push_back(t);
            for (int c = 0; c < NC; c++) begin
                bv = DW'(vb[c][i]);
                drv_b[c].push_back(bv);
                exp_b[c].push_back(bv);
                acc[c] = acc_step(acc[c], longint'(va[i]) * longint'(vb[c][i]));
            end
        end
        if (has_last) begin
            for (int c = 0; c < NC; c++) exp_c[c].push_back(fixed ? (c == 0 ? f0 : f1) : acc[c]);
        end
        va.delete();
        for (int c = 0; c < NC; c++) vb[c].delete();
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (pending() != 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk(name, pending(), 0);
    endtask

    task automatic wait_c(input int col, input string name);
        int n;
        n = 0;
        while (exp_c[col].size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk(name, exp_c[col].size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_c_out"}, c_out, 0);
        chk({tag, "_c_valid"}, c_valid, 0);
        chk({tag, "_a_out"}, a_out, 0);
        chk({tag, "_a_out_valid"}, a_out_valid, 0);
        chk({tag, "_a_out_last"}, a_out_last, 0);
        chk({tag, "_b_out"}, b_out, 0);
        chk({tag, "_b_out_valid"}, b_out_valid, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    // Drivers for A/B sources and the three sinks' ready lines.
    initial begin : drv
        bit a_hs;
        bit b_hs[NC];
        a_hs = 1'b0;
        for (int c = 0; c < NC; c++) b_hs[c] = 1'b0;
        a_in = '0; a_in_valid = 1'b0; a_in_last = 1'b0;
        b_in = '0; b_in_valid = '0;
        a_out_ready = 1'b1; b_out_ready = '1; c_ready = '1;
        forever begin
            @(negedge clk);
            if (a_hs) begin a_in_valid = 1'b0; a_hs = 1'b0; end
            if (rst && !a_in_valid && drv_a.size() != 0 && (!gap_en || $urandom_range(3, 0) != 0)) begin
                a_in = drv_a[0].d; a_in_last = drv_a[0].l; a_in_valid = 1'b1;
            end
            for (int c = 0; c < NC; c++) begin
                if (b_hs[c]) begin b_in_valid[c] = 1'b0; b_hs[c] = 1'b0; end
                if (rst && !b_in_valid[c] && drv_b[c].size() != 0 &&
                    (!gap_en || $urandom_range(3, 0) != 0)) begin
                    b_in[c*DW +: DW] = drv_b[c][0];
                    b_in_valid[c]    = 1'b1;
                end
                b_out_ready[c] = rand_ready ? ($urandom_range(3, 0) != 0) : 1'b1;
                c_ready[c]     = rand_ready ? ($urandom_range(1, 0) == 1) : c_ready_cfg[c];
            end
            a_out_ready = rand_ready ? ($urandom_range(3, 0) != 0) : 1'b1;
            #4;
            if (rst && a_in_valid && a_in_ready) begin
                a_hs = 1'b1;
                void'(drv_a.pop_front());
            end
            for (int c = 0; c < NC; c++) begin
                if (rst && b_in_valid[c] && b_in_ready[c]) begin
                    b_hs[c] = 1'b1;
                    void'(drv_b[c].pop_front());
                end
            end
        end
    end

    initial begin : mon
        tok_t                 t;
        logic [DW-1:0]        bv;
        logic signed [ACC-1:0] cv;
        for (int c = 0; c < NC; c++) cvc[c] = 0;
        forever begin
            @(negedge clk);
            #4;
            if (rst) begin
                if (a_out_valid && a_out_ready) begin
                    if (exp_a.size() == 0) chk("a_out_unexpected_token", 1, 0);
                    else begin
                        t = exp_a.pop_front();
                        chk("a_out_data", a_out, t.d);
                        chk("a_out_last", a_out_last, t.l);
                    end
                end
                for (int c = 0; c < NC; c++) begin
                    if (b_out_valid[c] && b_out_ready[c]) begin
                        if (exp_b[c].size() == 0) chk($sformatf("b_out%0d_unexpected", c), 1, 0);
                        else begin
                            bv = exp_b[c].pop_front();
                            chk($sformatf("b_out%0d_data", c), b_out[c*DW +: DW], bv);
                        end
                    end
                    if (c_valid[c]) cvc[c]++;
                    if (c_valid[c] && c_ready[c]) begin
                        cv = c_out[c*ACC +: ACC];
                        if (exp_c[c].size() == 0) chk($sformatf("c%0d_unexpected", c), 1, 0);
                        else chk($sformatf("c_out%0d", c), cv, exp_c[c].pop_front());
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached, pending=%0d", pending());
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int            base[NC];
        logic [3:0]    pat;
        longint        vals[2];
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #4 check_reset_outputs("por");
        @(negedge clk);
        rst = 1'b1;

        // Dot product with one-cycle C handshakes.
        for (int c = 0; c < NC; c++) base[c] = cvc[c];
        term(1, 4, -1); term(2, 5, -1); term(3, 6, -1);
        issue(1'b1, 1'b1, 32, -6);
        wait_drain("dot_drain");
        chk("dot_cvalid0_cycles", cvc[0] - base[0], 1);
        chk("dot_cvalid1_cycles", cvc[1] - base[1], 1);
        chk("dot_busy_idle", busy, 0);

        // Column 1 result held while PE1 stalls the next last term.
        @(posedge clk); c_ready_cfg = 2'b01;
        term(1, 4, -1); term(2, 5, -1); term(3, 6, -1);
        issue(1'b1, 1'b1, 32, -6);
        term(2, 3, 3);
        issue(1'b1, 1'b1, 6, 6);
        wait_c(0, "bp_c0_drain");
        repeat (5) @(negedge clk);
        #4;
        chk("bp_a_out_valid_low", a_out_valid, 0);
        chk("bp_c_valid1_held", c_valid[1], 1);
        chk("bp_c_out1_held", $signed(c_out[ACC +: ACC]), -6);
        @(posedge clk); c_ready_cfg = 2'b11;
        wait_drain("bp_drain");

        // Consume and reload C in the same cycle.
        @(posedge clk); c_ready_cfg = 2'b01;
        term(1, 2, 7);
        issue(1'b1, 1'b1, 2, 7);
        term(4, 1, 4);
        issue(1'b1, 1'b1, 4, 16);
        wait_c(0, "simul_c0_drain");
        repeat (5) @(negedge clk);
        @(posedge clk); c_ready_cfg = 2'b11;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #4;
            pat[k] = c_valid[1];
            if (k < 2) vals[k] = $signed(c_out[ACC +: ACC]);
        end
        chk("simul_cvalid_run", pat, 4'b0011);
        chk("simul_first_c", vals[0], 7);
        chk("simul_second_c", vals[1], 16);
        wait_drain("simul_drain");

        // Accumulator overflow.
        term(127, 127, 127); term(127, 127, 127); term(127, 127, 127);
`ifdef SYSTOLIC_ROW_SAT_EN
        issue(1'b1, 1'b1, 32767, 32767);
`else
        issue(1'b1, 1'b1, -17149, -17149);
`endif
        wait_drain("ovf_drain");

        // Random vectors, random gaps and random backpressure on every sink.
        @(posedge clk); rand_ready = 1'b1; gap_en = 1'b1;
        for (int v = 0; v < 30; v++) begin
            int len;
            len = int'($urandom_range(4, 1));
            for (int i = 0; i < len; i++) begin
                term(int'($urandom_range(255, 0)) - 128, int'($urandom_range(255, 0)) - 128,
                     int'($urandom_range(255, 0)) - 128);
            end
            issue(1'b1, 1'b0, 0, 0);
        end
        wait_drain("random_drain");
        @(posedge clk); rand_ready = 1'b0; gap_en = 1'b0;
        repeat (2) @(negedge clk);

        // Reset in the middle of a vector discards the partial sums.
        term(1, 3, 1); term(2, 4, 1);
        issue(1'b0, 1'b0, 0, 0);
        wait_drain("rst_partial_drain");
        chk("rst_busy_mid_vector", busy, 1);
        #2 rst = 1'b0;
        #1 check_reset_outputs("mid_rst");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        term(5, 5, 5);
        issue(1'b1, 1'b1, 25, 25);
        wait_drain("rst_fresh_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
